// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle MIPS core: loads a program into imem,
// lets the core run, and stops it on halt, PC overrun or watchdog expiry.
module cpu_run_controller #(
   parameter int          ADDR_W     = 6,
   parameter int          MAX_CYCLES = 1024,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              core_run,
   input  logic [31:0]       core_pc,
   input  logic [31:0]       core_instr,
   output logic              busy,
   output logic              done,
   output logic [1:0]        halt_cause,
   output logic [31:0]       instr_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3,
      S_HALTED  = 3'd4
   } state_e;

   localparam logic [ADDR_W-1:0] WCNT_LAST = {ADDR_W{1'b1}};
   localparam logic [31:0]       MAX_CNT   = 32'(MAX_CYCLES);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic [31:0]       instr_count_q, instr_count_d;
   logic [1:0]        halt_cause_q, halt_cause_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;

   logic halt_hit_s;
   logic overrun_s;
   logic watchdog_s;

   // Byte-address compare against load_count*4 is equivalent to a word compare.
   assign halt_hit_s = (core_instr == HALT_INSTR);
   assign overrun_s  = (core_pc >= {{(32-ADDR_W-3){1'b0}}, load_count_q, 2'b00});
   assign watchdog_s = (instr_count_q == MAX_CNT);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wcnt_q        <= {ADDR_W{1'b0}};
         load_count_q  <= {(ADDR_W+1){1'b0}};
         instr_count_q <= 32'd0;
         halt_cause_q  <= 2'b00;
         imem_we_q     <= 1'b0;
         imem_addr_q   <= {ADDR_W{1'b0}};
         imem_wdata_q  <= 32'd0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         load_count_q  <= load_count_d;
         instr_count_q <= instr_count_d;
         halt_cause_q  <= halt_cause_d;
         imem_we_q     <= imem_we_d;
         imem_addr_q   <= imem_addr_d;
         imem_wdata_q  <= imem_wdata_d;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      load_count_d  = load_count_q;
      instr_count_d = instr_count_q;
      halt_cause_d  = halt_cause_q;
      imem_we_d     = 1'b0;
      imem_addr_d   = imem_addr_q;
      imem_wdata_d  = imem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               wcnt_d  = {ADDR_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (load_valid) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = wcnt_q;
               imem_wdata_d = load_data;
               wcnt_d       = wcnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               // Full memory ends the load even without load_last.
               if (load_last || (wcnt_q == WCNT_LAST)) begin
                  state_d      = S_RELEASE;
                  load_count_d = {1'b0, wcnt_q} + {{ADDR_W{1'b0}}, 1'b1};
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_RELEASE: begin
            state_d       = S_RUN;
            instr_count_d = 32'd0;
         end
         S_RUN: begin
            if (halt_hit_s) begin
               state_d      = S_HALTED;
               halt_cause_d = 2'b01;
            end else if (overrun_s) begin
               state_d      = S_HALTED;
               halt_cause_d = 2'b10;
            end else if (watchdog_s) begin
               state_d      = S_HALTED;
               halt_cause_d = 2'b11;
            end else begin
               instr_count_d = instr_count_q + 32'd1;
            end
         end
         S_HALTED: begin
            if (start) begin
               state_d      = S_LOAD;
               wcnt_d       = {ADDR_W{1'b0}};
               halt_cause_d = 2'b00;
            end else begin
               state_d = S_HALTED;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State-decoded outputs; core_run is gated by the same stop conditions
   always_comb begin
      core_reset = 1'b1;
      core_run   = 1'b0;
      load_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            core_reset = 1'b1;
         end
         S_LOAD: begin
            load_ready = 1'b1;
            busy       = 1'b1;
         end
         S_RELEASE: begin
            busy = 1'b1;
         end
         S_RUN: begin
            core_reset = 1'b0;
            busy       = 1'b1;
            core_run   = ~(halt_hit_s | overrun_s | watchdog_s);
         end
         S_HALTED: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         default: begin
            core_reset = 1'b1;
         end
      endcase
   end

   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign halt_cause  = halt_cause_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller with a tiny behavioural core
// (PC + imem, beq-style branch) driving core_pc/core_instr.
module tb_cpu_run_controller;
   localparam int          ADDR_W = 6;
   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              load_valid = 1'b0;
   logic [31:0]       load_data = 32'd0;
   logic              load_last = 1'b0;
   logic              load_ready, imem_we, core_reset, core_run, busy, done;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata, core_pc, core_instr, instr_count;
   logic [1:0]        halt_cause;

   int checks = 0;
   int errors = 0;
   logic [37:0] wr_q[$];
   logic [33:0] halt_q[$];

   cpu_run_controller #(.ADDR_W(ADDR_W), .MAX_CYCLES(8), .HALT_INSTR(HALT)) dut (
      .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .core_run(core_run), .core_pc(core_pc),
      .core_instr(core_instr), .busy(busy), .done(done),
      .halt_cause(halt_cause), .instr_count(instr_count));

   always #5 clk = ~clk;

   // Behavioural core: imem + PC that only advances on core_run
   logic [31:0] mem [0:63];
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
   assign core_pc    = pc_q;
   assign core_instr = mem[pc_q[7:2]];
   always_comb begin
      pc_next = pc_q + 32'd4;
      if (core_instr[31:26] == 6'b000100)
         pc_next = pc_q + 32'd4 + {{14{core_instr[15]}}, core_instr[15:0], 2'b00};
   end
   always @(posedge clk) begin
      if (core_reset) pc_q <= 32'd0;
      else if (core_run) pc_q <= pc_next;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: pops expected imem writes and halt reports as the DUT presents them
   task automatic monitor();
      logic done_prev = 1'b0;
      logic [37:0] w;
      logic [33:0] h;
      forever begin
         @(negedge clk);
         if (imem_we) begin
            if (wr_q.size() == 0) chk("unexpected_write", 32'(imem_addr), 32'hDEAD_BEEF);
            else begin
               w = wr_q.pop_front();
               chk("wr_addr", 32'(imem_addr), 32'(w[37:32]));
               chk("wr_data", imem_wdata, w[31:0]);
            end
         end
         if (busy && !core_reset && core_instr == HALT) chk("run_on_halt_word", 32'(core_run), 32'd0);
         if (done && !done_prev) begin
            if (halt_q.size() == 0) chk("unexpected_halt", 32'(halt_cause), 32'hDEAD_BEEF);
            else begin
               h = halt_q.pop_front();
               chk("halt_cause", 32'(halt_cause), 32'(h[33:32]));
               chk("instr_count", instr_count, h[31:0]);
               chk("halt_core_reset", 32'(core_reset), 32'd0);
               chk("halt_core_run", 32'(core_run), 32'd0);
            end
         end
         done_prev = done;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, output bit acc);
      load_valid = 1'b1; load_data = d; load_last = last; acc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (load_ready) begin
            acc = 1'b1;
            wr_q.push_back({dut.wcnt_q, d});
            @(posedge clk); #1;
            break;
         end
      end
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_core_reset"}, 32'(core_reset), 32'd1);
      chk({nm, "_busy_done"}, {30'd0, busy, done}, 32'd0);
      chk({nm, "_load_ready"}, 32'(load_ready), 32'd0);
      chk({nm, "_core_run"}, 32'(core_run), 32'd0);
      chk({nm, "_imem_we"}, 32'(imem_we), 32'd0);
      chk({nm, "_imem_addr"}, 32'(imem_addr), 32'd0);
      chk({nm, "_imem_wdata"}, imem_wdata, 32'd0);
      chk({nm, "_halt_cause"}, 32'(halt_cause), 32'd0);
      chk({nm, "_instr_count"}, instr_count, 32'd0);
   endtask

   initial begin
      bit acc;
      int n;
      fork monitor(); join_none
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("rst");

      // T1/T2: three-word program, halt word at index 2
      pulse_start();
      send_word(32'h2001_0001, 1'b0, acc);
      send_word(32'h2002_0002, 1'b0, acc);
      halt_q.push_back({2'b01, 32'd2});
      send_word(HALT, 1'b1, acc);
      @(negedge clk);
      chk("release_core_reset", 32'(core_reset), 32'd1);
      chk("release_ready", 32'(load_ready), 32'd0);
      chk("release_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("run_core_reset", 32'(core_reset), 32'd0);
      chk("run_core_run", 32'(core_run), 32'd1);
      wait_done("t2");
      chk("t2_done", 32'(done), 32'd1);

      // T3: straight-line program runs off the end
      pulse_start();
      send_word(32'h2003_0003, 1'b0, acc);
      send_word(32'h2004_0004, 1'b0, acc);
      halt_q.push_back({2'b10, 32'd3});
      send_word(32'h2005_0005, 1'b1, acc);
      wait_done("t3");

      // T4: two-word loop hits the 8-instruction watchdog
      pulse_start();
      send_word(32'h2001_0001, 1'b0, acc);
      halt_q.push_back({2'b11, 32'd8});
      send_word(32'h1000_FFFE, 1'b1, acc);
      wait_done("t4");
      repeat (2) @(negedge clk);
      chk("t4_hold_core_reset", 32'(core_reset), 32'd0);
      chk("t4_hold_count", instr_count, 32'd8);

      // T5: overfill without load_last
      pulse_start();
      n = 0;
      for (int i = 0; i < 64; i++) begin
         send_word(32'h2000_0000 | 32'(i), 1'b0, acc);
         if (acc) n++;
      end
      halt_q.push_back({2'b11, 32'd8});
      @(negedge clk);
      chk("t5_ready_after_full", 32'(load_ready), 32'd0);
      chk("t5_release", {30'd0, busy, core_reset}, 32'd3);
      for (int i = 0; i < 5; i++) begin
         send_word(32'h3000_0000 | 32'(i), 1'b0, acc);
         if (acc) n++;
      end
      chk("t5_accepted", 32'(n), 32'd64);
      wait_done("t5");

      // T6a: reset in the middle of a load
      pulse_start();
      send_word(32'h1234_5678, 1'b0, acc);
      send_word(32'h9ABC_DEF0, 1'b0, acc);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("t6load");

      // T6b: reset in the middle of a run, then a clean restart
      pulse_start();
      send_word(32'h2001_0001, 1'b0, acc);
      send_word(32'h1000_FFFE, 1'b1, acc);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("t6run");
      pulse_start();
      send_word(32'h2001_0001, 1'b0, acc);
      halt_q.push_back({2'b01, 32'd1});
      send_word(HALT, 1'b1, acc);
      wait_done("t6");

      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("halt_q_drained", 32'(halt_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
